// File: rtl/back_ground_layers.sv
// ---------------------------------------------------------------------------
// back_ground_layers
//
// Background generator for the VGA path. Draws the default field colour, a
// one-pixel border ring, four bracket lines, and NUM_RECTS run-time
// programmable rectangles on top. The result is one registered RRRGGGBB pixel.
//
// Rectangle descriptors are written into a shadow bank at any time. The whole
// shadow bank is copied into the active bank on startOfFrame, so a frame
// never mixes old and new geometry.
//
// Optional feature (macro BG_BLINK_EN):
//   A frame counter toggles a blink phase every BLINK_FRAMES frames. While
//   the phase is 1 the bracket lines are hidden. Without the macro the
//   counter does not exist and the brackets are always drawn.
//
// Ports:
//   clk           pixel clock
//   resetN        asynchronous active-low reset
//   pixelX/Y      current pixel coordinates (11 bit)
//   startOfFrame  one-cycle pulse; commits shadow -> active
//   wrEn          write strobe for one rectangle descriptor
//   wrIdx         target layer; indices >= NUM_RECTS are ignored
//   wrX0..wrY1    inclusive rectangle bounds
//   wrColor       fill colour
//   wrEnable      layer visible when 1
//   BG_RGB        registered background pixel (1 clock latency)
//   layerHit      registered; pixel came from a rectangle
//   layerIdx      registered index of the winning rectangle, 0 if none
// ---------------------------------------------------------------------------
module back_ground_layers #(
    parameter  int X_FRAME        = 639,
    parameter  int Y_FRAME        = 479,
    parameter  int BRACKET_OFFSET = 10,
    parameter  int NUM_RECTS      = 4,
    parameter  int BLINK_FRAMES   = 30,
    localparam int IDX_W          = (NUM_RECTS > 1) ? $clog2(NUM_RECTS) : 1
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic [10:0]      pixelX,
    input  logic [10:0]      pixelY,
    input  logic             startOfFrame,
    input  logic             wrEn,
    input  logic [IDX_W-1:0] wrIdx,
    input  logic [10:0]      wrX0,
    input  logic [10:0]      wrX1,
    input  logic [10:0]      wrY0,
    input  logic [10:0]      wrY1,
    input  logic [7:0]       wrColor,
    input  logic             wrEnable,
    output logic [7:0]       BG_RGB,
    output logic             layerHit,
    output logic [3:0]       layerIdx
);

    // Elaboration-time parameter sanity checks.
    if (NUM_RECTS < 1 || NUM_RECTS > 16) begin : g_bad_num_rects
        $error("back_ground_layers: NUM_RECTS must be 1..16");
    end
    if (BLINK_FRAMES < 1 || BLINK_FRAMES > 255) begin : g_bad_blink_frames
        $error("back_ground_layers: BLINK_FRAMES must be 1..255");
    end

    localparam logic [7:0] COLOR_DEFAULT = 8'h58;
    localparam logic [7:0] COLOR_BORDER  = 8'hFC;
    localparam logic [7:0] COLOR_BRACKET = 8'hFF;
    localparam logic [7:0] COLOR_OFF     = 8'h00;
    localparam logic [7:0] COLOR_RESET   = 8'hFF;

    localparam logic [10:0] X_LAST    = 11'(X_FRAME);
    localparam logic [10:0] Y_LAST    = 11'(Y_FRAME);
    localparam logic [10:0] BR_LO     = 11'(BRACKET_OFFSET);
    localparam logic [10:0] BR_X_HI   = 11'(X_FRAME - BRACKET_OFFSET);
    localparam logic [10:0] BR_Y_HI   = 11'(Y_FRAME - BRACKET_OFFSET);

    typedef struct packed {
        logic [10:0] x0;
        logic [10:0] x1;
        logic [10:0] y0;
        logic [10:0] y1;
        logic [7:0]  color;
        logic        en;
    } rect_t;

    rect_t shadow_q [NUM_RECTS];
    rect_t shadow_d [NUM_RECTS];
    rect_t active_q [NUM_RECTS];
    rect_t active_d [NUM_RECTS];

    logic [7:0] bg_rgb_q,    bg_rgb_d;
    logic       layer_hit_q, layer_hit_d;
    logic [3:0] layer_idx_q, layer_idx_d;

    logic       bracket_hide;

    // -----------------------------------------------------------------------
    // Descriptor banks
    // -----------------------------------------------------------------------
    rect_t wr_desc;
    assign wr_desc = '{x0: wrX0, x1: wrX1, y0: wrY0, y1: wrY1,
                       color: wrColor, en: wrEnable};

    always_comb begin
        shadow_d = shadow_q;
        for (int k = 0; k < NUM_RECTS; k++) begin
            // Comparing against k (not indexing by wrIdx) drops out-of-range
            // indices naturally when NUM_RECTS is not a power of two.
            if (wrEn && (int'(wrIdx) == k)) begin
                shadow_d[k] = wr_desc;
            end
        end
    end

    // Commit takes the post-write shadow so a write in the commit cycle
    // lands in the same frame.
    always_comb begin
        active_d = active_q;
        if (startOfFrame) begin
            active_d = shadow_d;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int k = 0; k < NUM_RECTS; k++) begin
                shadow_q[k] <= '0;
                active_q[k] <= '0;
            end
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    // -----------------------------------------------------------------------
    // Bracket blink
    // -----------------------------------------------------------------------
`ifdef BG_BLINK_EN
    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

    logic [7:0] blink_cnt_q,   blink_cnt_d;
    logic       blink_phase_q, blink_phase_d;

    always_comb begin
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (startOfFrame) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d   = 8'd0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d   = blink_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            blink_cnt_q   <= 8'd0;
            blink_phase_q <= 1'b0;
        end else begin
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    assign bracket_hide = blink_phase_q;
`else
    assign bracket_hide = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Pixel path
    // -----------------------------------------------------------------------
    logic       in_view;
    logic       on_border;
    logic       on_bracket;
    logic       rect_hit;
    logic [3:0] rect_idx;
    logic [7:0] rect_color;

    assign in_view    = (pixelX <= X_LAST) && (pixelY <= Y_LAST);
    assign on_border  = (pixelX == 11'd0) || (pixelY == 11'd0) ||
                        (pixelX == X_LAST) || (pixelY == Y_LAST);
    assign on_bracket = (pixelX == BR_LO) || (pixelY == BR_LO) ||
                        (pixelX == BR_X_HI) || (pixelY == BR_Y_HI);

    // Parallel compares; a later (higher) index overrides an earlier one.
    // x0 > x1 or y0 > y1 can never satisfy both bounds, so such a
    // rectangle is simply empty.
    always_comb begin
        rect_hit   = 1'b0;
        rect_idx   = 4'd0;
        rect_color = 8'h00;
        for (int k = 0; k < NUM_RECTS; k++) begin
            if (active_q[k].en &&
                (pixelX >= active_q[k].x0) && (pixelX <= active_q[k].x1) &&
                (pixelY >= active_q[k].y0) && (pixelY <= active_q[k].y1)) begin
                rect_hit   = 1'b1;
                rect_idx   = 4'(k);
                rect_color = active_q[k].color;
            end
        end
    end

    always_comb begin
        bg_rgb_d    = COLOR_DEFAULT;
        layer_hit_d = 1'b0;
        layer_idx_d = 4'd0;
        if (!in_view) begin
            bg_rgb_d = COLOR_OFF;
        end else if (rect_hit) begin
            bg_rgb_d    = rect_color;
            layer_hit_d = 1'b1;
            layer_idx_d = rect_idx;
        end else if (on_bracket && !bracket_hide) begin
            bg_rgb_d = COLOR_BRACKET;
        end else if (on_border) begin
            bg_rgb_d = COLOR_BORDER;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            bg_rgb_q    <= COLOR_RESET;
            layer_hit_q <= 1'b0;
            layer_idx_q <= 4'd0;
        end else begin
            bg_rgb_q    <= bg_rgb_d;
            layer_hit_q <= layer_hit_d;
            layer_idx_q <= layer_idx_d;
        end
    end

    assign BG_RGB   = bg_rgb_q;
    assign layerHit = layer_hit_q;
    assign layerIdx = layer_idx_q;

endmodule

// File: tb/tb_back_ground_layers.sv
module tb_back_ground_layers;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic [10:0] pixelX = '0;
    logic [10:0] pixelY = '0;
    logic        startOfFrame = 1'b0;
    logic        wrEn = 1'b0;
    logic [1:0]  wrIdx = '0;
    logic [10:0] wrX0 = '0, wrX1 = '0, wrY0 = '0, wrY1 = '0;
    logic [7:0]  wrColor = '0;
    logic        wrEnable = 1'b0;
    logic [7:0]  BG_RGB;
    logic        layerHit;
    logic [3:0]  layerIdx;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [12:0] exp;
    } exp_t;
    exp_t sb[$];

    back_ground_layers #(
        .X_FRAME(639), .Y_FRAME(479), .BRACKET_OFFSET(10),
        .NUM_RECTS(4), .BLINK_FRAMES(2)
    ) dut (
        .clk(clk), .resetN(resetN),
        .pixelX(pixelX), .pixelY(pixelY),
        .startOfFrame(startOfFrame),
        .wrEn(wrEn), .wrIdx(wrIdx),
        .wrX0(wrX0), .wrX1(wrX1), .wrY0(wrY0), .wrY1(wrY1),
        .wrColor(wrColor), .wrEnable(wrEnable),
        .BG_RGB(BG_RGB), .layerHit(layerHit), .layerIdx(layerIdx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed rgb=%h hit=%b idx=%0d expected rgb=%h hit=%b idx=%0d",
                   tag, obs[12:5], obs[4], obs[3:0], exp[12:5], exp[4], exp[3:0]);
        end
    endtask

    // Drive one pixel, expect the result one clock later.
    task automatic px(input string tag, input int x, input int y, input logic sof,
                      input logic [7:0] rgb, input logic hit, input logic [3:0] idx);
        exp_t e;
        @(negedge clk);
        pixelX = 11'(x);
        pixelY = 11'(y);
        startOfFrame = sof;
        sb.push_back('{tag, {rgb, hit, idx}});
        @(posedge clk);
        #1;
        startOfFrame = 1'b0;
        e = sb.pop_front();
        check(e.tag, {BG_RGB, layerHit, layerIdx}, e.exp);
    endtask

    task automatic wr(input int idx, input int x0, input int x1, input int y0, input int y1,
                      input logic [7:0] c, input logic en, input logic sof);
        @(negedge clk);
        wrEn = 1'b1;
        wrIdx = 2'(idx);
        wrX0 = 11'(x0); wrX1 = 11'(x1); wrY0 = 11'(y0); wrY1 = 11'(y1);
        wrColor = c; wrEnable = en;
        startOfFrame = sof;
        @(posedge clk);
        #1;
        wrEn = 1'b0;
        startOfFrame = 1'b0;
    endtask

    task automatic do_sof();
        @(negedge clk);
        startOfFrame = 1'b1;
        @(posedge clk);
        #1;
        startOfFrame = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        resetN = 1'b0;
        @(negedge clk);
        resetN = 1'b1;
    endtask

    initial begin
        // Reset state
        #12;
        check("reset_state", {BG_RGB, layerHit, layerIdx}, {8'hFF, 1'b0, 4'd0});
        @(negedge clk);
        resetN = 1'b1;

        // Fixed background
        px("corner00",   0,   0, 0, 8'hFC, 0, 0);
        px("bracket_x",  10,  50, 0, 8'hFF, 0, 0);
        px("default",    100, 100, 0, 8'h58, 0, 0);
        px("offscreen",  700, 100, 0, 8'h00, 0, 0);
        px("corner_max", 639, 479, 0, 8'hFC, 0, 0);
        px("x_past_end", 640, 0,   0, 8'h00, 0, 0);
        px("y_past_end", 5,   480, 0, 8'h00, 0, 0);
        px("bracket_xh", 629, 200, 0, 8'hFF, 0, 0);
        px("bracket_yh", 200, 469, 0, 8'hFF, 0, 0);

        // Shadow write not visible until commit
        wr(1, 100, 200, 50, 80, 8'h03, 1, 0);
        px("uncommitted", 150, 60, 0, 8'h58, 0, 0);
        do_sof();
        px("l1_hit",    150, 60, 0, 8'h03, 1, 1);
        px("l1_right",  201, 60, 0, 8'h58, 0, 0);
        px("l1_corner", 200, 80, 0, 8'h03, 1, 1);
        px("l1_origin", 100, 50, 0, 8'h03, 1, 1);

        // Pixel sampled in the commit cycle uses the old active set
        wr(3, 50, 60, 300, 310, 8'h1F, 1, 0);
        px("commit_cycle", 55, 305, 1, 8'h58, 0, 0);
        px("after_commit", 55, 305, 0, 8'h1F, 1, 3);

        // Overlap priority
        wr(0, 110, 130, 110, 130, 8'hE0, 1, 0);
        wr(2, 115, 125, 115, 125, 8'h1C, 1, 0);
        do_sof();
        px("overlap_hi", 120, 120, 0, 8'h1C, 1, 2);
        px("overlap_lo", 112, 112, 0, 8'hE0, 1, 0);
        wr(2, 115, 125, 115, 125, 8'h1C, 0, 0);
        do_sof();
        px("l2_disabled", 120, 120, 0, 8'hE0, 1, 0);

        // Write and commit in the same cycle; reversed bounds are empty
        wr(0, 300, 299, 200, 210, 8'hE0, 1, 1);
        px("empty_rect", 300, 205, 0, 8'h58, 0, 0);
        wr(0, 300, 300, 200, 210, 8'hE0, 1, 1);
        px("one_col",    300, 205, 0, 8'hE0, 1, 0);
        px("one_col_r",  301, 205, 0, 8'h58, 0, 0);
        px("one_col_l",  299, 205, 0, 8'h58, 0, 0);
        px("one_col_y",  300, 211, 0, 8'h58, 0, 0);

        // Asynchronous reset mid-frame
        px("pre_reset", 300, 205, 0, 8'hE0, 1, 0);
        @(negedge clk);
        #2;
        resetN = 1'b0;
        #1;
        check("async_reset", {BG_RGB, layerHit, layerIdx}, {8'hFF, 1'b0, 4'd0});
        @(negedge clk);
        resetN = 1'b1;
        px("post_rst_l0", 300, 205, 0, 8'h58, 0, 0);
        px("post_rst_l1", 150, 60,  0, 8'h58, 0, 0);
        do_sof();
        px("post_rst_sof", 150, 60, 0, 8'h58, 0, 0);

`ifdef BG_BLINK_EN
        pulse_reset();
        px("blink_f0",  10, 50, 0, 8'hFF, 0, 0);
        px("blink_b0",  0,  0,  0, 8'hFC, 0, 0);
        for (int f = 1; f < 6; f++) begin
            do_sof();
            px($sformatf("blink_f%0d", f), 10, 50, 0,
               (f == 2 || f == 3) ? 8'h58 : 8'hFF, 0, 0);
            px($sformatf("blink_b%0d", f), 0, 0, 0, 8'hFC, 0, 0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
